// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 MAR/MDR memory interface.
package lc3_mem_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam word_t MMIO_BASE = 16'hFE00;

endpackage

// File: rtl/mem_access_ctrl.sv
// LC-3 MAR/MDR initiator: single-word reads/writes with optional wait states.
// Build option LC3_MMIO_EN maps addresses >= MMIO_BASE onto the io_* port set.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req,
  input  logic  req_we,
  input  word_t req_addr,
  input  word_t req_wdata,
  output logic  busy,
  output logic  done,
  output word_t rdata,
  output logic  addr_err,
  input  word_t memOut,
  output logic  memWE,
  output word_t mdrOut,
  output word_t MARReg
`ifdef LC3_MMIO_EN
  ,
  output logic  io_rd,
  output logic  io_wr,
  output word_t io_wdata,
  input  word_t io_rdata
`endif
);

  mem_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic               op_we;
  logic               oor;
  logic               is_io;
  logic               req_io_c;
  logic               req_oor_c;
  logic               last_c;
  word_t              rd_sel_c;

  // Classify the incoming address; the io window is never out of range.
`ifdef LC3_MMIO_EN
  assign req_io_c = (req_addr >= MMIO_BASE);
`else
  assign req_io_c = 1'b0;
`endif
  assign req_oor_c = !req_io_c && (32'(req_addr) >= MEM_DEPTH);

  assign last_c = (state == ACCESS) && (cnt == '0);
  assign memWE  = last_c && op_we && !oor && !is_io;
  assign rdata  = mdrOut;

`ifdef LC3_MMIO_EN
  assign io_rd    = last_c && !op_we && is_io;
  assign io_wr    = last_c && op_we && is_io;
  assign io_wdata = mdrOut;
  assign rd_sel_c = is_io ? io_rdata : (oor ? '0 : memOut);
`else
  assign rd_sel_c = oor ? '0 : memOut;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_we    <= 1'b0;
      oor      <= 1'b0;
      is_io    <= 1'b0;
      MARReg   <= '0;
      mdrOut   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            MARReg <= req_addr;
            if (req_we) mdrOut <= req_wdata;
            op_we  <= req_we;
            oor    <= req_oor_c;
            is_io  <= req_io_c;
            cnt    <= CNT_W'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Write data was captured by the memory at this edge; reads load the MDR.
            if (!op_we) mdrOut <= rd_sel_c;
            done     <= 1'b1;
            addr_err <= oor;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: two controllers (0 and 3 wait states) against a word-array reference.
module tb_mem_access_ctrl;
  import lc3_mem_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic       clk;
  logic       reset;
  logic [1:0] req, req_we, busy, done, addr_err, memWE;
  word_t      req_addr[2], req_wdata[2], rdata[2], memOut[2], mdrOut[2], MARReg[2];
`ifdef LC3_MMIO_EN
  logic [1:0] io_rd, io_wr;
  word_t      io_wdata[2], io_rdata[2];
`endif

  int n_asrt = 0;
  int n_fail = 0;

  word_t mem[2][DEPTH];
  word_t model[2][DEPTH];
  bit    mem_init_done;

  mem_access_ctrl #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req(req[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .addr_err(addr_err[0]), .memOut(memOut[0]), .memWE(memWE[0]),
    .mdrOut(mdrOut[0]), .MARReg(MARReg[0])
`ifdef LC3_MMIO_EN
    , .io_rd(io_rd[0]), .io_wr(io_wr[0]), .io_wdata(io_wdata[0]), .io_rdata(io_rdata[0])
`endif
  );

  mem_access_ctrl #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req(req[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .addr_err(addr_err[1]), .memOut(memOut[1]), .memWE(memWE[1]),
    .mdrOut(mdrOut[1]), .MARReg(MARReg[1])
`ifdef LC3_MMIO_EN
    , .io_rd(io_rd[1]), .io_wr(io_wr[1]), .io_wdata(io_wdata[1]), .io_rdata(io_rdata[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t init_word(input int i, input int a);
    return word_t'(a * 40503 + i * 7919) ^ 16'h5A5A;
  endfunction

  // Word memories: combinational read, write on the clock edge while memWE is high.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < int'(DEPTH); a++) mem[i][a] <= init_word(i, a);
      mem_init_done <= 1'b1;
    end else begin
      if (memWE[0]) mem[0][MARReg[0][7:0]] <= mdrOut[0];
      if (memWE[1]) mem[1][MARReg[1][7:0]] <= mdrOut[1];
    end
  end
  assign memOut[0] = mem[0][MARReg[0][7:0]];
  assign memOut[1] = mem[1][MARReg[1][7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on controller i; expectations come from the address map rules.
  task automatic txn(input int i, input bit we, input word_t addr, input word_t wd, input bit glitch);
    int    ws, k, busy_n, we_n, iow_n, ior_n;
    bit    got, io, inr, exp_err;
    word_t exp_rd, io_val;
    ws     = (i == 0) ? 0 : 3;
    inr    = (32'(addr) < DEPTH);
    io     = 1'b0;
    io_val = '0;
`ifdef LC3_MMIO_EN
    io          = (addr >= 16'hFE00);
    io_val      = word_t'($urandom);
    io_rdata[i] = io_val;
`endif
    exp_err = !io && !inr;
    if (we)       exp_rd = wd;
    else if (io)  exp_rd = io_val;
    else if (inr) exp_rd = model[i][addr[7:0]];
    else          exp_rd = '0;

    @(negedge clk);
    req[i] = 1'b1; req_we[i] = we; req_addr[i] = addr; req_wdata[i] = wd;
    got = 1'b0; k = 0; busy_n = 0; we_n = 0; iow_n = 0; ior_n = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      k++;
      if (busy[i]) busy_n++;
      if (memWE[i]) begin
        we_n++;
        chk("memwe_addr", 32'(MARReg[i]), 32'(addr));
        chk("memwe_data", 32'(mdrOut[i]), 32'(wd));
      end
`ifdef LC3_MMIO_EN
      if (io_wr[i]) begin
        iow_n++;
        chk("io_wdata", 32'(io_wdata[i]), 32'(wd));
      end
      if (io_rd[i]) ior_n++;
`endif
      if (done[i]) got = 1'b1;
      else if (glitch && k <= ws) begin
        req[i] = 1'b1; req_we[i] = 1'($urandom);
        req_addr[i] = word_t'($urandom); req_wdata[i] = word_t'($urandom);
      end else req[i] = 1'b0;
    end
    req[i] = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(k), 32'(ws + 2));
    chk("busy_cycles", 32'(busy_n), 32'(ws + 2));
    chk("addr_err", 32'(addr_err[i]), 32'(exp_err));
    chk("rdata", 32'(rdata[i]), 32'(exp_rd));
    chk("memwe_cycles", 32'(we_n), (we && inr) ? 32'd1 : 32'd0);
`ifdef LC3_MMIO_EN
    chk("io_wr_cycles", 32'(iow_n), (we && io) ? 32'd1 : 32'd0);
    chk("io_rd_cycles", 32'(ior_n), (!we && io) ? 32'd1 : 32'd0);
`endif
    if (we && inr) model[i][addr[7:0]] = wd;
    @(negedge clk);
    chk("done_pulse", 32'(done[i]), 32'd0);
    chk("idle_busy", 32'(busy[i]), 32'd0);
    chk("addr_err_clr", 32'(addr_err[i]), 32'd0);
    chk("rdata_hold", 32'(rdata[i]), 32'(exp_rd));
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
    chk({tag, "_done"}, 32'(done[i]), 32'd0);
    chk({tag, "_memwe"}, 32'(memWE[i]), 32'd0);
    chk({tag, "_err"}, 32'(addr_err[i]), 32'd0);
    chk({tag, "_mar"}, 32'(MARReg[i]), 32'd0);
    chk({tag, "_mdr"}, 32'(mdrOut[i]), 32'd0);
  endtask

  initial begin
    int    dn;
    word_t a;
    reset = 1'b0;
    req = '0; req_we = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0;
`ifdef LC3_MMIO_EN
      io_rdata[i] = '0;
`endif
      for (int j = 0; j < int'(DEPTH); j++) model[i][j] = init_word(i, j);
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst3");
    reset = 1'b1;

    txn(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    txn(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    txn(0, 1'b1, 16'h0100, 16'h1234, 1'b0);
    txn(0, 1'b0, 16'h0100, 16'h0000, 1'b0);
    txn(0, 1'b1, 16'hFFFF, 16'h0F0F, 1'b0);

    // Reset during the final access cycle of a write must suppress it.
    @(negedge clk);
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0020; req_wdata[0] = 16'h5A5A;
    @(negedge clk);
    req[0] = 1'b0;
    chk("pre_reset_memwe", 32'(memWE[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk_zero(0, "midrst");
    chk("midrst_rdata", 32'(rdata[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    chk("no_done_after_abort", 32'(dn), 32'd0);
    txn(0, 1'b0, 16'h0020, 16'h0000, 1'b0);

    txn(0, 1'b1, 16'hFE06, 16'h0041, 1'b0);
    txn(1, 1'b0, 16'hFE04, 16'h0000, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom % 4)
        0, 1:    a = word_t'($urandom_range(0, DEPTH - 1));
        2:       a = word_t'($urandom_range(DEPTH, 16'hFDFF));
        default: a = word_t'($urandom_range(16'hFE00, 16'hFFFF));
      endcase
      txn(int'($urandom % 2), 1'($urandom), a, word_t'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
